// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================
// Module   : multicycle_ctrl_if
// Function : control/handshake bundle between FSM and datapath
// Revision : 1.0
// ============================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_wen;
  logic             ir_we;
  logic [2:0]       imm_sel;
  logic             alu_src_a;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_wen, ir_we, imm_sel, alu_src_a, alu_src_b,
           alu_op, pc_we, pc_sel, reg_we, wb_sel, state, trap, retired
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_wen, ir_we, imm_sel, alu_src_a, alu_src_b,
           alu_op, pc_we, pc_sel, reg_we, wb_sel, state, trap, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================
// Module   : multicycle_ctrl
// Function : RV32I multi-cycle control FSM with retire counter and trap
// Revision : 1.0
// ============================================================
module multicycle_ctrl #(
  parameter int CNT_W      = 32,
  parameter int RESET_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_fetch  = 3'd1;
  localparam logic [2:0] c_decode = 3'd2;
  localparam logic [2:0] c_exec   = 3'd3;
  localparam logic [2:0] c_mem    = 3'd4;
  localparam logic [2:0] c_wb     = 3'd5;
  localparam logic [2:0] c_trap   = 3'd6;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  localparam logic [2:0] c_imm_none = 3'd0;
  localparam logic [2:0] c_imm_i    = 3'd1;
  localparam logic [2:0] c_imm_s    = 3'd2;
  localparam logic [2:0] c_imm_b    = 3'd3;
  localparam logic [2:0] c_imm_u    = 3'd4;
  localparam logic [2:0] c_imm_j    = 3'd5;

  localparam logic [3:0]       c_hold_last = 4'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] c_ret_one   = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [3:0]       r_hold;
  logic             r_trap;
  logic [CNT_W-1:0] r_retired;

  logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic       w_alu_hold, w_legal;
  logic [2:0] w_imm_fmt;
  logic [3:0] w_alu_ctl;  // {alu_src_a, alu_src_b, alu_op}

  logic       w_imem_req, w_dmem_req, w_dmem_wen, w_ir_we;
  logic [2:0] w_imm_sel;
  logic       w_alu_src_a, w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_pc_we, w_reg_we, w_retire;
  logic [1:0] w_pc_sel, w_wb_sel;

  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_alu_hold  = 1'b0;
    w_legal     = 1'b1;
    w_imm_fmt   = c_imm_none;
    w_alu_ctl   = 4'b0000;
    case (bus.opcode)
      c_op_load:   begin w_is_load = 1'b1;   w_imm_fmt = c_imm_i; w_alu_ctl = 4'b0100; end
      c_op_store:  begin w_is_store = 1'b1;  w_imm_fmt = c_imm_s; w_alu_ctl = 4'b0100; end
      c_op_branch: begin w_is_branch = 1'b1; w_imm_fmt = c_imm_b; w_alu_ctl = 4'b0001; end
      c_op_op:     begin w_alu_hold = 1'b1;  w_alu_ctl = 4'b0010; end
      c_op_opimm:  begin w_alu_hold = 1'b1;  w_imm_fmt = c_imm_i; w_alu_ctl = 4'b0110; end
      c_op_lui:    begin w_alu_hold = 1'b1;  w_imm_fmt = c_imm_u; w_alu_ctl = 4'b0111; end
      c_op_auipc:  begin w_alu_hold = 1'b1;  w_imm_fmt = c_imm_u; w_alu_ctl = 4'b1100; end
      c_op_jal:    begin w_is_jal = 1'b1;    w_imm_fmt = c_imm_j; end
      c_op_jalr:   begin
        w_is_jalr  = 1'b1;
        w_alu_hold = 1'b1;
        w_imm_fmt  = c_imm_i;
        w_alu_ctl  = 4'b0100;
      end
      default:     w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_wen  = 1'b0;
    w_ir_we     = 1'b0;
    w_imm_sel   = c_imm_none;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 1'b0;
    w_alu_op    = 2'd0;
    w_pc_we     = 1'b0;
    w_pc_sel    = 2'd0;
    w_reg_we    = 1'b0;
    w_wb_sel    = 2'd0;
    w_retire    = 1'b0;
    case (r_state)
      c_idle: begin
        if (r_hold == c_hold_last) w_next = c_fetch;
      end
      c_fetch: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = c_decode;
        end
      end
      c_decode: begin
        w_imm_sel = w_imm_fmt;
        w_next    = w_legal ? c_exec : c_trap;
      end
      c_exec: begin
        w_imm_sel = w_imm_fmt;
        {w_alu_src_a, w_alu_src_b, w_alu_op} = w_alu_ctl;
        if (w_is_branch) begin
          w_pc_we  = 1'b1;
          w_pc_sel = bus.branch_taken ? 2'd1 : 2'd0;
          w_retire = 1'b1;
          w_next   = c_fetch;
        end else if (w_is_load || w_is_store) begin
          w_next = c_mem;
        end else begin
          w_next = c_wb;
        end
      end
      c_mem: begin
        w_imm_sel  = w_imm_fmt;
        w_dmem_req = 1'b1;
        w_dmem_wen = w_is_store;
        if (bus.dmem_ready) begin
          if (w_is_store) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = c_fetch;
          end else begin
            w_next = c_wb;
          end
        end
      end
      c_wb: begin
        w_imm_sel = w_imm_fmt;
        w_reg_we  = 1'b1;
        w_pc_we   = 1'b1;
        w_retire  = 1'b1;
        w_wb_sel  = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
        w_pc_sel  = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
        // Keep the ALU result stable while it is being written back
        if (w_alu_hold) {w_alu_src_a, w_alu_src_b, w_alu_op} = w_alu_ctl;
        w_next = c_fetch;
      end
      c_trap:  w_next = c_trap;
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_hold    <= 4'd0;
      r_trap    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_idle && r_hold != c_hold_last) r_hold <= r_hold + 4'd1;
      if (w_next == c_trap) r_trap <= 1'b1;
      if (w_retire) r_retired <= r_retired + c_ret_one;
    end
  end

  assign bus.imem_req  = w_imem_req;
  assign bus.dmem_req  = w_dmem_req;
  assign bus.dmem_wen  = w_dmem_wen;
  assign bus.ir_we     = w_ir_we;
  assign bus.imm_sel   = w_imm_sel;
  assign bus.alu_src_a = w_alu_src_a;
  assign bus.alu_src_b = w_alu_src_b;
  assign bus.alu_op    = w_alu_op;
  assign bus.pc_we     = w_pc_we;
  assign bus.pc_sel    = w_pc_sel;
  assign bus.reg_we    = w_reg_we;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.state     = r_state;
  assign bus.trap      = r_trap;
  assign bus.retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================
// Module   : tb_multicycle_ctrl
// Function : self-checking bench for multicycle_ctrl
// Revision : 1.0
// ============================================================
module tb_multicycle_ctrl;
  localparam int CNT_W      = 4;
  localparam int RESET_HOLD = 1;

  localparam int K_LOAD = 0, K_STORE = 1, K_BR = 2, K_OP = 3, K_OPIMM = 4;
  localparam int K_LUI = 5, K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_wen;
    logic       ir_we;
    logic [2:0] imm_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    bit         taken;
    int         iw;
    int         dw;
    int         cycles;
    logic [2:0] imm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   model_ret = 0;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
  multicycle_ctrl #(.CNT_W(CNT_W), .RESET_HOLD(RESET_HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b0110011: return K_OP;
      7'b0010011: return K_OPIMM;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int k);
    case (k)
      K_LOAD, K_OPIMM, K_JALR: return 3'd1;
      K_STORE:                 return 3'd2;
      K_BR:                    return 3'd3;
      K_LUI, K_AUIPC:          return 3'd4;
      K_JAL:                   return 3'd5;
      default:                 return 3'd0;
    endcase
  endfunction

  // {alu_src_a, alu_src_b, alu_op} used by each instruction kind in EXEC
  function automatic logic [3:0] alu_of(input int k);
    case (k)
      K_BR:                     return 4'b0001;
      K_LOAD, K_STORE, K_JALR:  return 4'b0100;
      K_OP:                     return 4'b0010;
      K_OPIMM:                  return 4'b0110;
      K_LUI:                    return 4'b0111;
      K_AUIPC:                  return 4'b1100;
      default:                  return 4'b0000;
    endcase
  endfunction

  // Expected controls for an instruction kind while it sits in phase ph
  function automatic ctl_t exp_ctl(input int k, input int ph, input bit rdy, input bit taken);
    ctl_t e = '0;
    e.state = 3'(ph);
    if (ph >= 2 && ph <= 5) e.imm_sel = imm_of(k);
    case (ph)
      1: begin e.imem_req = 1'b1; e.ir_we = rdy; end
      3: begin
        {e.alu_src_a, e.alu_src_b, e.alu_op} = alu_of(k);
        if (k == K_BR) begin e.pc_we = 1'b1; e.pc_sel = taken ? 2'd1 : 2'd0; end
      end
      4: begin
        e.dmem_req = 1'b1;
        e.dmem_wen = (k == K_STORE);
        e.pc_we    = (k == K_STORE) && rdy;
      end
      5: begin
        e.reg_we = 1'b1;
        e.pc_we  = 1'b1;
        e.wb_sel = (k == K_LOAD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        e.pc_sel = (k == K_JAL) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
        if (k inside {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JALR})
          {e.alu_src_a, e.alu_src_b, e.alu_op} = alu_of(k);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t s;
    s.state     = bus.state;
    s.imem_req  = bus.imem_req;
    s.dmem_req  = bus.dmem_req;
    s.dmem_wen  = bus.dmem_wen;
    s.ir_we     = bus.ir_we;
    s.imm_sel   = bus.imm_sel;
    s.alu_src_a = bus.alu_src_a;
    s.alu_src_b = bus.alu_src_b;
    s.alu_op    = bus.alu_op;
    s.pc_we     = bus.pc_we;
    s.pc_sel    = bus.pc_sel;
    s.reg_we    = bus.reg_we;
    s.wb_sel    = bus.wb_sel;
    return s;
  endfunction

  task automatic check_ctl(input string name, input ctl_t exp);
    ctl_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: controls got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_stat(input string name, input bit trp);
    logic [CNT_W-1:0] exp_ret;
    exp_ret = CNT_W'(model_ret % (1 << CNT_W));
    checks++;
    if (bus.retired !== exp_ret || bus.trap !== trp) begin
      errors++;
      $display("FAIL %s_stat: retired/trap got %0d/%b expected %0d/%b",
               name, bus.retired, bus.trap, exp_ret, trp);
    end
  endtask

  // One clock: compare mid-cycle, then advance past the next rising edge
  task automatic cyc(input string name, input ctl_t exp, input bit trp, output ctl_t got);
    @(negedge clk);
    got = sample();
    check_ctl(name, exp);
    check_stat(name, trp);
    @(posedge clk);
    #1;
    if (exp.pc_we) model_ret++;
  endtask

  task automatic do_reset();
    ctl_t got;
    rst_n            = 1'b0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.opcode       = 7'd0;
    bus.branch_taken = 1'b0;
    model_ret        = 0;
    repeat (2) @(posedge clk);
    #1;
    check_ctl("reset_outputs", '0);
    check_stat("reset", 1'b0);
    rst_n          = 1'b1;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < RESET_HOLD; i++) cyc("idle", exp_ctl(K_ILL, 0, 1'b0, 1'b0), 1'b0, got);
  endtask

  task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input bit taken,
                           input int abort_at, output int ncyc, output logic [2:0] dec_imm);
    int   k;
    ctl_t got;
    k       = kind_of(op);
    ncyc    = 0;
    dec_imm = 3'd0;
    bus.branch_taken = taken;
    bus.dmem_ready   = 1'b0;
    for (int c = 0; c <= iw; c++) begin
      bus.opcode     = 7'($urandom);
      bus.imem_ready = (c == iw);
      cyc("fetch", exp_ctl(k, 1, c == iw, taken), 1'b0, got);
      ncyc++;
    end
    bus.opcode     = op;
    bus.imem_ready = 1'($urandom);
    cyc("decode", exp_ctl(k, 2, 1'b0, taken), 1'b0, got);
    dec_imm = got.imm_sel;
    ncyc++;
    if (k == K_ILL) return;
    bus.imem_ready = 1'($urandom);
    cyc("exec", exp_ctl(k, 3, 1'b0, taken), 1'b0, got);
    ncyc++;
    if (k == K_BR) return;
    if (k == K_LOAD || k == K_STORE) begin
      for (int c = 0; c <= dw; c++) begin
        if (c == abort_at) begin
          rst_n          = 1'b0;
          bus.dmem_ready = 1'b1;
          #1;
          model_ret = 0;
          check_ctl("abort_outputs", '0);
          check_stat("abort", 1'b0);
          return;
        end
        bus.dmem_ready = (c == dw);
        cyc("mem", exp_ctl(k, 4, c == dw, taken), 1'b0, got);
        ncyc++;
      end
      bus.dmem_ready = 1'b0;
      if (k == K_STORE) return;
    end
    cyc("wb", exp_ctl(k, 5, 1'b0, taken), 1'b0, got);
    ncyc++;
  endtask

  initial begin
    vec_t       tbl[13];
    logic [6:0] legal[9];
    int         n;
    logic [2:0] imm;
    ctl_t       got;

    tbl[0]  = '{7'b0010011, 1'b0, 0, 0, 4, 3'd1};  // addi
    tbl[1]  = '{7'b0100011, 1'b0, 0, 3, 7, 3'd2};  // sw, slow dmem
    tbl[2]  = '{7'b1100011, 1'b1, 0, 0, 3, 3'd3};  // beq taken
    tbl[3]  = '{7'b1100011, 1'b0, 0, 0, 3, 3'd3};  // beq not taken
    tbl[4]  = '{7'b1101111, 1'b0, 0, 0, 4, 3'd5};  // jal
    tbl[5]  = '{7'b0000011, 1'b0, 2, 0, 7, 3'd1};  // lw, slow imem
    tbl[6]  = '{7'b0110011, 1'b0, 0, 0, 4, 3'd0};  // add
    tbl[7]  = '{7'b0110111, 1'b0, 0, 0, 4, 3'd4};  // lui
    tbl[8]  = '{7'b0010111, 1'b0, 0, 0, 4, 3'd4};  // auipc
    tbl[9]  = '{7'b1100111, 1'b0, 0, 0, 4, 3'd1};  // jalr
    tbl[10] = '{7'b0000011, 1'b0, 0, 0, 5, 3'd1};  // lw zero-wait
    tbl[11] = '{7'b0100011, 1'b0, 0, 0, 4, 3'd2};  // sw zero-wait
    tbl[12] = '{7'b0000011, 1'b1, 1, 2, 8, 3'd1};  // lw, both slow
    legal = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    rst_n            = 1'b1;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.opcode       = 7'd0;
    bus.branch_taken = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].op, tbl[i].iw, tbl[i].dw, tbl[i].taken, -1, n, imm);
      checks++;
      if (n != tbl[i].cycles) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles expected %0d", i, n, tbl[i].cycles);
      end
      checks++;
      if (imm !== tbl[i].imm) begin
        errors++;
        $display("FAIL imm_sel[%0d]: got %0d expected %0d", i, imm, tbl[i].imm);
      end
    end

    // Illegal opcode lands in TRAP and stays there whatever the inputs do
    run_instr(7'b1111111, 1, 0, 1'b0, -1, n, imm);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ready   = 1'($urandom);
      bus.dmem_ready   = 1'($urandom);
      bus.branch_taken = 1'($urandom);
      bus.opcode       = legal[$urandom_range(0, 8)];
      cyc("trap", exp_ctl(K_ILL, 6, 1'b0, 1'b0), 1'b1, got);
    end

    do_reset();
    for (int i = 0; i < 60; i++) begin
      run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), -1, n, imm);
    end

    // Reset in the middle of a load's MEM wait, then a clean restart
    run_instr(7'b0000011, 0, 4, 1'b0, 2, n, imm);
    @(posedge clk);
    #1;
    check_ctl("abort_hold", '0);
    do_reset();
    run_instr(7'b0010011, 0, 0, 1'b0, -1, n, imm);
    @(negedge clk);
    check_stat("restart", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
